// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);
    localparam logic [31:0] ADDR_INC       = 32'd4;

endpackage

// File: rtl/idle_timer.sv
// Counts enabled cycles up to IDLE_TIMEOUT and then holds there with expired set.
module idle_timer #(
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic clk_i,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(IDLE_TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != LIMIT)
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Streams UART bytes into instruction RAM as little-endian 32-bit words.
// Optional checksum_o output is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [31:0]       wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [ADDR_W:0]   word_count_o,
    output logic [7:0]        checksum_o
`else
    output logic [ADDR_W:0]   word_count_o
`endif
);

    state_t        state, state_nxt;
    logic [31:0]   addr;
    logic [31:0]   word;
    logic [1:0]    idx;
    logic [ADDR_W:0] count;
    logic          flush;
    logic          xfer;
    logic          expired;
    logic          at_last;

    assign xfer    = byte_valid_i && (state == RECV);
    assign at_last = &addr[ADDR_W+1:2];

    idle_timer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_timer (
        .clk_i   (clk_i),
        .reset   (reset),
        .clear   (xfer || state == IDLE),
        .enable  (state == RECV && !xfer),
        .expired (expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        byte_ready_o = 1'b0;
        wr_en_o      = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = RECV;
            end
            RECV: begin
                byte_ready_o = 1'b1;
                if (xfer) begin
                    if (idx == LAST_BYTE_IDX) state_nxt = WRITE;
                end else if (expired) begin
                    state_nxt = (idx == 2'd0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                wr_en_o   = 1'b1;
                // The last RAM word ends the load so the address never wraps.
                state_nxt = (flush || at_last) ? DONE : RECV;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            addr  <= '0;
            word  <= '0;
            idx   <= '0;
            count <= '0;
            flush <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    addr  <= '0;
                    word  <= '0;
                    idx   <= '0;
                    count <= '0;
                    flush <= 1'b0;
                end
                RECV: begin
                    if (xfer) begin
                        word[{idx, 3'b000} +: 8] <= byte_i;
                        idx <= idx + 2'd1;
                    end else if (expired && idx != 2'd0) begin
                        flush <= 1'b1;
                    end
                end
                WRITE: begin
                    // Clearing the word here provides the zero padding for a partial flush.
                    word  <= '0;
                    idx   <= '0;
                    count <= count + 1'b1;
                    if (!at_last) addr <= addr + ADDR_INC;
                end
                default: ;
            endcase
        end
    end

    assign wr_addr_o    = wr_en_o ? addr : 32'd0;
    assign wr_data_o    = wr_en_o ? word : 32'd0;
    assign word_count_o = count;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cksum;

    always_ff @(posedge clk_i) begin
        if (reset || (state == IDLE && start_i))
            cksum <= '0;
        else if (xfer)
            cksum <= cksum + byte_i;
    end

    assign checksum_o = cksum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-list reference model.
module tb_imem_loader;

    localparam int AW    = 2;
    localparam int TO    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int CAP   = 4 * DEPTH;

    logic          clk_i = 1'b0;
    logic          reset;
    logic          start;
    logic          bv;
    logic [7:0]    bd;
    logic          byte_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    imem_loader #(.ADDR_W(AW), .IDLE_TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .start_i      (start),
        .byte_valid_i (bv),
        .byte_i       (bd),
        .byte_ready_o (byte_ready),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .done_o       (done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .word_count_o (word_count),
        .checksum_o   (checksum)
`else
        .word_count_o (word_count)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t wq[$];
    int  done_cnt = 0;
    int  nchk = 0;
    int  nerr = 0;

    always @(negedge clk_i) begin
        if (wr_en) wq.push_back('{wr_addr, wr_data});
        if (done)  done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit acc);
        int n = 0;
        bv = 1'b1;
        bd = b;
        if (acc) begin
            while (!byte_ready && n < 20) begin
                @(negedge clk_i);
                n++;
            end
            chk("accept_wait", 32'(n < 20), 32'd1);
            @(negedge clk_i);
        end else begin
            chk("ready_low", 32'(byte_ready), 32'd0);
            @(negedge clk_i);
        end
        bv = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("done_wait", 32'(n < 200), 32'd1);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    // Full load: expected words come straight from the byte list, 4 bytes per word,
    // little-endian, zero-padded, truncated to the RAM depth.
    task automatic run_load(input logic [7:0] bytes[$], input int maxgap);
        int          d0, acc, nw;
        logic [31:0] w;
        logic [7:0]  sum;
        wq.delete();
        d0 = done_cnt;
        pulse_start();
        foreach (bytes[i]) begin
            send_byte(bytes[i], i < CAP);
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk_i);
        end
        wait_done(d0);
        @(negedge clk_i);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ready_idle", 32'(byte_ready), 32'd0);
        acc = (bytes.size() < CAP) ? bytes.size() : CAP;
        nw  = (acc + 3) / 4;
        chk("nwrites", 32'(wq.size()), 32'(nw));
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int b = 0; b < 4; b++)
                if (4 * k + b < acc) w[8*b +: 8] = bytes[4*k + b];
            if (k < wq.size()) begin
                chk("wr_addr", wq[k].a, 32'(4 * k));
                chk("wr_data", wq[k].d, w);
            end
        end
        chk("word_count", 32'(word_count), 32'(nw));
        sum = '0;
        for (int i = 0; i < acc; i++) sum = sum + bytes[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(sum));
`endif
    endtask

    initial begin
        logic [7:0] q[$];
        int         sz, d0;
        reset = 1'b1;
        start = 1'b0;
        bv    = 1'b0;
        bd    = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", wr_addr, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        @(negedge clk_i);

        q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(q, 0);

        q = {8'hAA, 8'hBB};
        run_load(q, 0);

        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        run_load(q, 2);

        q.delete();
        run_load(q, 0);

        q = {8'hFF, 8'h02};
        run_load(q, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("checksum_ff02", 32'(checksum), 32'h01);
`endif

        for (int t = 0; t < 12; t++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(22, 0)); i++) q.push_back(8'($urandom));
            run_load(q, 4);
        end

        // start_i during RECV must not reset address or count
        wq.delete();
        d0 = done_cnt;
        pulse_start();
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 5; i++) send_byte(q[i], 1'b1);
        pulse_start();
        for (int i = 5; i < 8; i++) send_byte(q[i], 1'b1);
        wait_done(d0);
        chk("mid_start_nw", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("mid_start_a1", wq[1].a, 32'd4);
            chk("mid_start_d1", wq[1].d, 32'h08070605);
        end
        chk("mid_start_cnt", 32'(word_count), 32'd2);

        // reset mid-load discards the partial word
        @(negedge clk_i);
        wq.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
        reset = 1'b1;
        @(negedge clk_i);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(word_count), 32'd0);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        reset = 1'b0;
        sz = wq.size();
        repeat (40) @(negedge clk_i);
        chk("midrst_nowr", 32'(wq.size()), 32'(sz));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the instruction RAM word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1000000, meaning the number of clk_i cycles without a byte that ends a load.
REQ-003 SHALL have port clk_i  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse that begins a program load.
REQ-006 SHALL have port byte_valid_i  input  1  a byte is offered on byte_i (from the UART receiver).
REQ-007 SHALL have port byte_i  input  8  the offered program byte.
REQ-008 SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid_i and byte_ready_o are both 1.
REQ-009 SHALL have port wr_en_o  output  1  instruction RAM write strobe, one cycle per word.
REQ-010 SHALL have port wr_addr_o  output  32  byte address of the word being written, always 4-aligned.
REQ-011 SHALL have port wr_data_o  output  32  word being written.
REQ-012 SHALL have port busy_o  output  1  load in progress; holds the CPU and the fetch PC in reset.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse when a load completes.
REQ-014 SHALL have port word_count_o  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-015 SHALL implement an FSM with states IDLE, RECV, WRITE and DONE.
REQ-016 IDLE SHALL move to RECV on start_i; it SHALL clear the address, byte index, word count and timer.
REQ-017 RECV SHALL hold byte_ready_o=1; in every other state byte_ready_o SHALL be 0.
REQ-018 Bytes SHALL be assembled little-endian: byte index 0 goes to bits 7:0, and so on up to index 3 at bits 31:24.
REQ-019 Accepting the fourth byte SHALL move the FSM to WRITE on the next cycle.
REQ-020 WRITE SHALL last exactly one cycle: wr_en_o=1, wr_data_o=the assembled word, wr_addr_o=the current address.
REQ-021 After WRITE, the address SHALL increment by 4 and word_count_o by 1, and the FSM SHALL return to RECV.
REQ-022 The idle timer SHALL count RECV cycles with no transfer and SHALL clear on each transfer.
REQ-023 On timer reaching IDLE_TIMEOUT with byte index 0, the FSM SHALL go to DONE.
REQ-024 On timer reaching IDLE_TIMEOUT with a partial word, the unfilled bytes SHALL be zero-padded, one WRITE SHALL be issued, and the FSM SHALL then go to DONE.
REQ-025 A WRITE to the last word address (word 2^ADDR_W-1) SHALL be followed by DONE, never by an address wrap-around.
REQ-026 DONE SHALL assert done_o for one cycle and then return to IDLE.
REQ-027 busy_o SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-028 start_i SHALL be ignored outside IDLE.
REQ-029 word_count_o SHALL hold its value in IDLE until the next start_i.

Reset
REQ-030 reset SHALL force IDLE in the same edge, including mid-load, discarding any partial word.
REQ-031 After reset, all outputs SHALL be 0: byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o and word_count_o.

Configuration
REQ-032 With macro IMEM_LOADER_CHECKSUM_EN defined, an output port checksum_o (8 bits) SHALL be present.
REQ-033 checksum_o SHALL hold the modulo-256 sum of all accepted bytes; it SHALL clear on start_i and on reset.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN, checksum_o and its adder SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-035 Package imem_loader_pkg SHALL hold the FSM state typedef, BYTES_PER_WORD=4 and the WRITE address increment constant 4.
REQ-036 The idle timer SHALL be a sub-module idle_timer with ports clear, enable and expired, parameterised by IDLE_TIMEOUT.

Verification
REQ-037 Reset, then start_i, then bytes 13,00,00,00 and 93,00,10,00 -> two WRITEs: addr 0 data 0x00000013, then addr 4 data 0x00100093; after timeout, done_o and word_count_o=2.
REQ-038 With IDLE_TIMEOUT=16, start then bytes AA,BB and 16 idle cycles -> WRITE addr 0 data 0x0000BBAA, then done_o.
REQ-039 With ADDR_W=2, send 20 bytes -> 4 WRITEs at addr 0,4,8,C, then DONE; byte_ready_o=0 for bytes 17-20.
REQ-040 Reset asserted after 6 bytes -> next cycle busy_o=0, word_count_o=0, no further wr_en_o.
REQ-041 start_i pulsed during RECV -> address and count are unaffected.
REQ-042 With IMEM_LOADER_CHECKSUM_EN, bytes FF,02 -> checksum_o=0x01.
